spi_io_target: RTL and testbench

Oversampled, parametrised quad/dual/single-lane SPI target (CPOL=0, CPHA=0) running entirely in the system clock domain. Host-side `sclk`/`cs`/data are synchronised and edge-detected, then a command/receive/dummy/transmit state machine exchanges fixed-length payloads with the fabric. It replaces the direct-`sclk`-clocked HID bridge and adds host-to-device payloads, configurable lane count, abort handling and optional CRC.

---
 rtl/spi_io_pkg.sv | 43 ++++
 rtl/spi_io_sync.sv | 45 ++++
 rtl/spi_io_target.sv | 257 +++++++++++++++++++++++++
 tb/tb_spi_io_target.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_io_pkg.sv
// Shared types and helpers for the spi_io_target SPI device: FSM states,
// command codes, command decode helpers and the CRC-8 (poly 0x07) step.
package spi_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COMMAND  = 3'd1,
    ST_RECEIVE  = 3'd2,
    ST_DUMMY    = 3'd3,
    ST_TRANSMIT = 3'd4,
    ST_DONE     = 3'd5
  } spi_state;

  typedef enum logic [7:0] {
    CMD_GET_STATUS = 8'h50,
    CMD_SET        = 8'h90,
    CMD_XFER       = 8'hD0
  } command_code;

  function automatic logic cmd_defined(input logic [7:0] code);
    return (code == CMD_GET_STATUS) || (code == CMD_SET) || (code == CMD_XFER);
  endfunction

  // Named from the host's view: "read" means the device transmits (bit 6),
  // "write" means the device receives (bit 7).
  function automatic logic cmd_has_read(input logic [7:0] code);
    return cmd_defined(code) && code[6];
  endfunction

  function automatic logic cmd_has_write(input logic [7:0] code);
    return cmd_defined(code) && code[7];
  endfunction

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_io_sync.sv
// Synchroniser for the host-side SPI pins plus sclk/cs edge strobes.
// Data uses the same depth as sclk so it is valid alongside the rise strobe.
module spi_io_sync
  import spi_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk,
  input  logic [3:0] d_in,
  output logic       cs_s,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_rise,
  output logic       cs_fall,
  output logic [3:0] d_s
);

  // One extra stage on cs/sclk holds the previous synchronised value.
  logic [SYNC_STAGES:0]     cs_q;
  logic [SYNC_STAGES:0]     sclk_q;
  logic [4*SYNC_STAGES-1:0] d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q   <= '1;
      sclk_q <= '0;
      d_q    <= '0;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-1:0], cs};
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      d_q    <= {d_q[4*SYNC_STAGES-5:0], d_in};
    end
  end

  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
  assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
  assign d_s       = d_q[4*SYNC_STAGES-1 -: 4];

endmodule

// File: rtl/spi_io_target.sv
// Oversampled SPI target (CPOL=0, CPHA=0) with 1/2/4 lanes, clocked by clk only.
// Define SPI_IO_CRC_EN to append a CRC-8 to TX payloads and check one on RX.
module spi_io_target
  import spi_io_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int TX_BYTES     = 16,
  parameter int RX_BYTES     = 8,
  parameter int DUMMY_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sclk,
  input  logic [3:0]            d_in,
  output logic [3:0]            d_out,
  output logic [3:0]            d_oe,
  input  logic [8*TX_BYTES-1:0] tx_data,
  output logic                  tx_latch,
  output logic [8*RX_BYTES-1:0] rx_data,
  output logic                  rx_valid,
  output logic [7:0]            cmd,
  output logic                  busy,
  output logic                  abort,
  output logic                  cmd_error,
  output logic                  crc_error
);

`ifdef SPI_IO_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int TX_TOTAL  = 8 * TX_BYTES + CRC_BITS;
  localparam int RX_TOTAL  = 8 * RX_BYTES + CRC_BITS;
  localparam int MAX_BYTES = (TX_BYTES > RX_BYTES) ? TX_BYTES : RX_BYTES;
  localparam int CW        = $clog2(8 * MAX_BYTES + 16);

  localparam logic [CW-1:0] STEP      = CW'(LANES);
  localparam logic [CW-1:0] CMD_BITS  = CW'(8);
  localparam logic [CW-1:0] RX_LAST   = CW'(RX_TOTAL);
  localparam logic [CW-1:0] TX_LAST   = CW'(TX_TOTAL);
  localparam logic [CW-1:0] DUMMY_END = CW'(DUMMY_CYCLES);
  localparam logic [3:0]    LANE_MASK = (LANES == 1) ? 4'b0010 :
                                        (LANES == 2) ? 4'b0011 : 4'b1111;

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_check
    $error("spi_io_target: LANES must be 1, 2 or 4");
  end

  logic       cs_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [3:0] d_s;

  spi_io_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .sclk      (sclk),
    .d_in      (d_in),
    .cs_s      (cs_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .d_s       (d_s)
  );

  spi_state              state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [7:0]            cmd_shift_q, cmd_shift_d, cmd_next;
  logic [7:0]            cmd_q, cmd_d;
  logic [RX_TOTAL-1:0]   rx_shift_q, rx_shift_d, rx_next;
  logic [TX_TOTAL-1:0]   tx_shift_q, tx_shift_d, tx_load;
  logic [8*RX_BYTES-1:0] rx_data_q, rx_data_d;
  logic [3:0]            d_out_q, d_out_d, tx_sym;
  logic                  tx_latch_q, tx_latch_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  abort_q, abort_d;
  logic                  cmd_error_q, cmd_error_d;
  logic                  crc_error_q, crc_error_d;
  logic                  rx_crc_ok;
  logic                  done_evt;

  assign cnt_inc  = cnt_q + STEP;
  assign cmd_next = {cmd_shift_q[7-LANES:0], d_s[LANES-1:0]};
  assign rx_next  = {rx_shift_q[RX_TOTAL-LANES-1:0], d_s[LANES-1:0]};

  // Single-lane output goes out on the miso_d1 pad.
  if (LANES == 1) begin : g_sym_single
    assign tx_sym = {2'b00, tx_shift_q[TX_TOTAL-1], 1'b0};
  end else begin : g_sym_multi
    assign tx_sym = 4'(tx_shift_q[TX_TOTAL-1 -: LANES]);
  end

`ifdef SPI_IO_CRC_EN
  logic [7:0] tx_crc, rx_crc;

  always_comb begin
    tx_crc = 8'h00;
    for (int i = 0; i < TX_BYTES; i++) begin
      tx_crc = crc8_step(tx_crc, tx_data[8*(TX_BYTES-i)-1 -: 8]);
    end
    tx_load = {tx_data, tx_crc};
  end

  always_comb begin
    rx_crc = 8'h00;
    for (int i = 0; i < RX_BYTES; i++) begin
      rx_crc = crc8_step(rx_crc, rx_next[RX_TOTAL-1-8*i -: 8]);
    end
    rx_crc_ok = (rx_crc == rx_next[7:0]);
  end
`else
  assign tx_load   = tx_data;
  assign rx_crc_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_shift_d = cmd_shift_q;
    cmd_d       = cmd_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    d_out_d     = d_out_q;
    tx_latch_d  = 1'b0;
    rx_valid_d  = 1'b0;
    abort_d     = 1'b0;
    cmd_error_d = 1'b0;
    crc_error_d = 1'b0;
    done_evt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_COMMAND;
          cnt_d   = '0;
        end
      end
      ST_COMMAND: begin
        if (sclk_rise) begin
          cmd_shift_d = cmd_next;
          cnt_d       = cnt_inc;
          if (cnt_inc == CMD_BITS) begin
            cnt_d = '0;
            cmd_d = cmd_next;
            if (!cmd_defined(cmd_next)) begin
              cmd_error_d = 1'b1;
              done_evt    = 1'b1;
              state_d     = ST_DONE;
            end else begin
              if (cmd_has_read(cmd_next)) begin
                tx_latch_d = 1'b1;
                tx_shift_d = tx_load;
              end
              state_d = cmd_has_write(cmd_next) ? ST_RECEIVE : ST_DUMMY;
            end
          end
        end
      end
      ST_RECEIVE: begin
        if (sclk_rise) begin
          rx_shift_d = rx_next;
          cnt_d      = cnt_inc;
          if (cnt_inc == RX_LAST) begin
            cnt_d    = '0;
            done_evt = 1'b1;
            if (rx_crc_ok) begin
              rx_data_d  = rx_next[RX_TOTAL-1 -: 8*RX_BYTES];
              rx_valid_d = 1'b1;
            end else begin
              crc_error_d = 1'b1;
            end
            state_d = cmd_has_read(cmd_q) ? ST_DUMMY : ST_DONE;
          end
        end
      end
      ST_DUMMY: begin
        // Count dummy rises; the fall after the last one presents the first symbol.
        if (sclk_rise) begin
          cnt_d = cnt_q + CW'(1);
        end else if (sclk_fall && cnt_q == DUMMY_END) begin
          d_out_d    = tx_sym;
          tx_shift_d = tx_shift_q << LANES;
          cnt_d      = '0;
          state_d    = ST_TRANSMIT;
        end
      end
      ST_TRANSMIT: begin
        if (sclk_rise) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TX_LAST) begin
            done_evt = 1'b1;
            state_d  = ST_DONE;
          end
        end else if (sclk_fall) begin
          d_out_d    = tx_sym;
          tx_shift_d = tx_shift_q << LANES;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    // A completion on the same cycle as cs rising is not treated as an abort.
    if (cs_rise && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      abort_d = (state_q != ST_DONE) && !done_evt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_shift_q <= '0;
      cmd_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      d_out_q     <= '0;
      tx_latch_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      abort_q     <= 1'b0;
      cmd_error_q <= 1'b0;
      crc_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_shift_q <= cmd_shift_d;
      cmd_q       <= cmd_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      d_out_q     <= d_out_d;
      tx_latch_q  <= tx_latch_d;
      rx_valid_q  <= rx_valid_d;
      abort_q     <= abort_d;
      cmd_error_q <= cmd_error_d;
      crc_error_q <= crc_error_d;
    end
  end

  assign d_out     = d_out_q;
  assign d_oe      = (state_q == ST_TRANSMIT) ? LANE_MASK : 4'b0000;
  assign tx_latch  = tx_latch_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign cmd       = cmd_q;
  assign busy      = ~cs_s;
  assign abort     = abort_q;
  assign cmd_error = cmd_error_q;
  assign crc_error = crc_error_q;

endmodule

// File: tb/tb_spi_io_target.sv
// Directed bench for spi_io_target: one instance each for LANES=1, 2 and 4.
// Build with SPI_IO_CRC_EN defined to exercise the CRC byte handling.
module tb_spi_io_target;

  localparam int HALF = 6;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         sclk  = 1'b0;
  logic [2:0]   cs_a  = 3'b111;
  logic [3:0]   d_in  = 4'h0;
  logic [127:0] tx_data;

  logic [3:0]  dout_a [3];
  logic [3:0]  oe_a   [3];
  logic [63:0] rxd_a  [3];
  logic [7:0]  cmd_a  [3];
  logic [2:0]  txl_a, rxv_a, busy_a, abort_a, cerr_a, crcerr_a;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    spi_io_target #(.LANES(L)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cs        (cs_a[gi]),
      .sclk      (sclk),
      .d_in      (d_in),
      .d_out     (dout_a[gi]),
      .d_oe      (oe_a[gi]),
      .tx_data   (tx_data),
      .tx_latch  (txl_a[gi]),
      .rx_data   (rxd_a[gi]),
      .rx_valid  (rxv_a[gi]),
      .cmd       (cmd_a[gi]),
      .busy      (busy_a[gi]),
      .abort     (abort_a[gi]),
      .cmd_error (cerr_a[gi]),
      .crc_error (crcerr_a[gi])
    );
  end

  // Pulse counters per instance
  int   n_txl [3] = '{0, 0, 0};
  int   n_rxv [3] = '{0, 0, 0};
  int   n_abt [3] = '{0, 0, 0};
  int   n_cer [3] = '{0, 0, 0};
  int   n_crc [3] = '{0, 0, 0};
  logic oe1_seen  = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (txl_a[i])    n_txl[i]++;
      if (rxv_a[i])    n_rxv[i]++;
      if (abort_a[i])  n_abt[i]++;
      if (cerr_a[i])   n_cer[i]++;
      if (crcerr_a[i]) n_crc[i]++;
    end
    if (oe_a[0] != 4'h0) oe1_seen = 1'b1;
  end

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         idx, lanes, oe_bad;
  logic [3:0] oe_expect;
  int         b_txl, b_rxv, b_abt, b_cer, b_crc;
  logic [7:0] r;
  logic [3:0] o, e;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] txb(input int i);
    case (i)
      0:       return 8'hAB;
      1:       return 8'hCD;
      default: return 8'(8'h30 + i);
    endcase
  endfunction

  function automatic logic [7:0] crc8_model(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ data[b];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // One SCLK cycle: present data, rise (host samples), fall.
  task automatic sym(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
    d_in = din;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    dout = dout_a[idx];
    oe   = oe_a[idx];
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] b, output logic [7:0] rb);
    logic [7:0] sh;
    logic [3:0] s, so, se;
    sh = b;
    rb = '0;
    for (int k = 0; k < 8 / lanes; k++) begin
      case (lanes)
        1:       s = {3'b000, sh[7]};
        2:       s = {2'b00, sh[7:6]};
        default: s = sh[7:4];
      endcase
      sh = sh << lanes;
      sym(s, so, se);
      case (lanes)
        1:       rb = {rb[6:0], so[1]};
        2:       rb = {rb[5:0], so[1:0]};
        default: rb = {rb[3:0], so};
      endcase
      if (se !== oe_expect) oe_bad++;
    end
  endtask

  task automatic send_payload(input logic [63:0] p);
    logic [7:0] rr;
`ifdef SPI_IO_CRC_EN
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 8; i++) c = crc8_model(c, p[63-8*i -: 8]);
`endif
    for (int i = 0; i < 8; i++) xbyte(p[63-8*i -: 8], rr);
`ifdef SPI_IO_CRC_EN
    xbyte(c, rr);
`endif
  endtask

  task automatic read_tx(input string tag);
    logic [7:0] rr;
`ifdef SPI_IO_CRC_EN
    logic [7:0] c;
    c = 8'h00;
`endif
    for (int i = 0; i < 16; i++) begin
      xbyte(8'h00, rr);
      check(tag, rr, txb(i));
`ifdef SPI_IO_CRC_EN
      c = crc8_model(c, txb(i));
`endif
    end
`ifdef SPI_IO_CRC_EN
    xbyte(8'h00, rr);
    check({tag, "_crc"}, rr, c);
`endif
  endtask

  task automatic start_txn(input int which);
    idx       = which;
    lanes     = (which == 0) ? 1 : (which == 1) ? 2 : 4;
    oe_bad    = 0;
    oe_expect = 4'h0;
    b_txl = n_txl[idx]; b_rxv = n_rxv[idx]; b_abt = n_abt[idx];
    b_cer = n_cer[idx]; b_crc = n_crc[idx];
    cs_a[idx] = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic stop_txn;
    repeat (HALF) @(negedge clk);
    cs_a[idx] = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  initial begin
    tx_data = '0;
    for (int i = 0; i < 16; i++) tx_data[8*(16-i)-1 -: 8] = txb(i);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_d_out", dout_a[2], 4'h0);
    check("rst_d_oe", oe_a[2], 4'h0);
    check("rst_rx_data", rxd_a[2], 64'h0);
    check("rst_cmd", cmd_a[2], 8'h00);
    check("rst_busy", busy_a, 3'b000);
    check("rst_pulses", {txl_a, rxv_a, abort_a, cerr_a, crcerr_a}, 15'h0);
    $display("[TB] txn reset checked");

    // GET_STATUS on 4 lanes
    start_txn(2);
    xbyte(8'h50, r);
    check("t1_cmd", cmd_a[2], 8'h50);
    check("t1_busy", busy_a[2], 1'b1);
    sym(4'h0, o, e); if (e !== oe_expect) oe_bad++;
    sym(4'h0, o, e); if (e !== oe_expect) oe_bad++;
    oe_expect = 4'hF;
    read_tx("t1_tx_byte");
    stop_txn();
    check("t1_oe", oe_bad, 0);
    check("t1_oe_after", oe_a[2], 4'h0);
    check("t1_busy_after", busy_a[2], 1'b0);
    check("t1_tx_latch", n_txl[2] - b_txl, 1);
    check("t1_abort", n_abt[2] - b_abt, 0);
    $display("[TB] txn GET_STATUS lanes=4");

    // SET on 1 lane
    start_txn(0);
    xbyte(8'h90, r);
    send_payload(64'h0102030405060708);
    stop_txn();
    check("t2_rx_valid", n_rxv[0] - b_rxv, 1);
    check("t2_rx_data", rxd_a[0], 64'h0102030405060708);
    check("t2_cmd", cmd_a[0], 8'h90);
    check("t2_oe_seen", oe1_seen, 1'b0);
    check("t2_crc_err", n_crc[0] - b_crc, 0);
    $display("[TB] txn SET lanes=1");

    // XFER on 2 lanes
    start_txn(1);
    xbyte(8'hD0, r);
    send_payload(64'hA0A1A2A3A4A5A6A7);
    sym(4'h0, o, e); if (e !== oe_expect) oe_bad++;
    sym(4'h0, o, e); if (e !== oe_expect) oe_bad++;
    oe_expect = 4'h3;
    read_tx("t3_tx_byte");
    stop_txn();
    check("t3_cmd", cmd_a[1], 8'hD0);
    check("t3_rx_data", rxd_a[1], 64'hA0A1A2A3A4A5A6A7);
    check("t3_rx_valid", n_rxv[1] - b_rxv, 1);
    check("t3_tx_latch", n_txl[1] - b_txl, 1);
    check("t3_oe", oe_bad, 0);
    $display("[TB] txn XFER lanes=2");

    // Undefined command
    start_txn(2);
    xbyte(8'h33, r);
    check("t4_cmd", cmd_a[2], 8'h33);
    xbyte(8'h00, r);
    xbyte(8'h00, r);
    stop_txn();
    check("t4_cmd_error", n_cer[2] - b_cer, 1);
    check("t4_oe", oe_bad, 0);
    check("t4_abort", n_abt[2] - b_abt, 0);
    check("t4_tx_latch", n_txl[2] - b_txl, 0);
    $display("[TB] txn undefined cmd 0x33");

    // Good SET, then aborted SET, then good SET on 4 lanes
    start_txn(2);
    xbyte(8'h90, r);
    send_payload(64'h1112131415161718);
    stop_txn();
    check("t5a_rx_data", rxd_a[2], 64'h1112131415161718);
    check("t5a_rx_valid", n_rxv[2] - b_rxv, 1);
    $display("[TB] txn SET lanes=4");

    start_txn(2);
    xbyte(8'h90, r);
    for (int i = 0; i < 3; i++) xbyte(8'h99, r);
    stop_txn();
    check("t5b_abort", n_abt[2] - b_abt, 1);
    check("t5b_rx_valid", n_rxv[2] - b_rxv, 0);
    check("t5b_rx_data", rxd_a[2], 64'h1112131415161718);
    $display("[TB] txn aborted SET lanes=4");

    start_txn(2);
    xbyte(8'h90, r);
    send_payload(64'h2122232425262728);
    stop_txn();
    check("t5c_rx_data", rxd_a[2], 64'h2122232425262728);
    check("t5c_rx_valid", n_rxv[2] - b_rxv, 1);
    check("t5c_abort", n_abt[2] - b_abt, 0);
    $display("[TB] txn SET after abort lanes=4");

`ifdef SPI_IO_CRC_EN
    start_txn(2);
    xbyte(8'h90, r);
    for (int i = 0; i < 8; i++) xbyte(8'h00, r);
    xbyte(8'h01, r);
    stop_txn();
    check("t6a_crc_error", n_crc[2] - b_crc, 1);
    check("t6a_rx_valid", n_rxv[2] - b_rxv, 0);
    check("t6a_rx_data", rxd_a[2], 64'h2122232425262728);
    $display("[TB] txn SET bad crc lanes=4");

    start_txn(2);
    xbyte(8'h90, r);
    for (int i = 0; i < 8; i++) xbyte(8'h00, r);
    xbyte(8'h00, r);
    stop_txn();
    check("t6b_crc_error", n_crc[2] - b_crc, 0);
    check("t6b_rx_valid", n_rxv[2] - b_rxv, 1);
    check("t6b_rx_data", rxd_a[2], 64'h0);
    $display("[TB] txn SET good crc lanes=4");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
